// File: rtl/ysyx_23060236_arbiter.sv
// ============================================================================
// ysyx_23060236_arbiter - whole-transaction round-robin IFU/LSU AXI4 arbiter. Rev 1.0
// ============================================================================
`default_nettype none

module ysyx_23060236_arbiter (
    input  logic        clock,
    input  logic        reset,
    // IFU read master
    input  logic        ifu_arvalid,
    input  logic [31:0] ifu_araddr,
    input  logic [3:0]  ifu_arid,
    input  logic [7:0]  ifu_arlen,
    input  logic [2:0]  ifu_arsize,
    input  logic [1:0]  ifu_arburst,
    output logic        ifu_arready,
    output logic        ifu_rvalid,
    output logic [1:0]  ifu_rresp,
    output logic [31:0] ifu_rdata,
    output logic        ifu_rlast,
    output logic [3:0]  ifu_rid,
    input  logic        ifu_rready,
    // LSU read/write master
    input  logic        lsu_arvalid,
    input  logic [31:0] lsu_araddr,
    input  logic [3:0]  lsu_arid,
    input  logic [7:0]  lsu_arlen,
    input  logic [2:0]  lsu_arsize,
    input  logic [1:0]  lsu_arburst,
    output logic        lsu_arready,
    output logic        lsu_rvalid,
    output logic [1:0]  lsu_rresp,
    output logic [31:0] lsu_rdata,
    output logic        lsu_rlast,
    output logic [3:0]  lsu_rid,
    input  logic        lsu_rready,
    input  logic        lsu_awvalid,
    input  logic [31:0] lsu_awaddr,
    input  logic [3:0]  lsu_awid,
    input  logic [7:0]  lsu_awlen,
    input  logic [2:0]  lsu_awsize,
    input  logic [1:0]  lsu_awburst,
    output logic        lsu_awready,
    input  logic        lsu_wvalid,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic        lsu_wlast,
    output logic        lsu_wready,
    output logic        lsu_bvalid,
    output logic [1:0]  lsu_bresp,
    output logic [3:0]  lsu_bid,
    input  logic        lsu_bready,
    // Merged master toward the MMU
    output logic        out_awvalid,
    input  logic        out_awready,
    output logic [31:0] out_awaddr,
    output logic [3:0]  out_awid,
    output logic [7:0]  out_awlen,
    output logic [2:0]  out_awsize,
    output logic [1:0]  out_awburst,
    output logic        out_wvalid,
    input  logic        out_wready,
    output logic [31:0] out_wdata,
    output logic [3:0]  out_wstrb,
    output logic        out_wlast,
    input  logic        out_bvalid,
    output logic        out_bready,
    input  logic [1:0]  out_bresp,
    input  logic [3:0]  out_bid,
    output logic        out_arvalid,
    input  logic        out_arready,
    output logic [31:0] out_araddr,
    output logic [3:0]  out_arid,
    output logic [7:0]  out_arlen,
    output logic [2:0]  out_arsize,
    output logic [1:0]  out_arburst,
    input  logic        out_rvalid,
    output logic        out_rready,
    input  logic [1:0]  out_rresp,
    input  logic [31:0] out_rdata,
    input  logic        out_rlast,
    input  logic [3:0]  out_rid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   last_grant_q, last_grant_d;   // 0 = IFU, 1 = LSU
    logic   lsu_req;

    assign lsu_req = lsu_awvalid | lsu_arvalid;

    // Response payloads are broadcast; only the valids are steered.
    assign ifu_rresp = out_rresp;
    assign ifu_rdata = out_rdata;
    assign ifu_rlast = out_rlast;
    assign ifu_rid   = out_rid;
    assign lsu_rresp = out_rresp;
    assign lsu_rdata = out_rdata;
    assign lsu_rlast = out_rlast;
    assign lsu_rid   = out_rid;
    assign lsu_bresp = out_bresp;
    assign lsu_bid   = out_bid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        ifu_arready  = 1'b0;
        ifu_rvalid   = 1'b0;
        lsu_arready  = 1'b0;
        lsu_rvalid   = 1'b0;
        lsu_awready  = 1'b0;
        lsu_wready   = 1'b0;
        lsu_bvalid   = 1'b0;
        out_awvalid  = 1'b0;
        out_awaddr   = 32'd0;
        out_awid     = 4'd0;
        out_awlen    = 8'd0;
        out_awsize   = 3'b010;
        out_awburst  = 2'd0;
        out_wvalid   = 1'b0;
        out_wdata    = 32'd0;
        out_wstrb    = 4'd0;
        out_wlast    = 1'b0;
        out_bready   = 1'b0;
        out_arvalid  = 1'b0;
        out_araddr   = 32'd0;
        out_arid     = 4'd0;
        out_arlen    = 8'd0;
        out_arsize   = 3'b010;
        out_arburst  = 2'd0;
        out_rready   = 1'b0;

        case (state_q)
            IDLE: begin
                // LSU wins on contention unless it held the previous grant.
                if (lsu_req && (!ifu_arvalid || !last_grant_q)) begin
                    state_d      = lsu_awvalid ? LSU_WR : LSU_RD;
                    last_grant_d = 1'b1;
                end else if (ifu_arvalid) begin
                    state_d      = IFU_RD;
                    last_grant_d = 1'b0;
                end
            end
            IFU_RD: begin
                out_arvalid = ifu_arvalid;
                out_araddr  = ifu_araddr;
                out_arid    = ifu_arid;
                out_arlen   = ifu_arlen;
                out_arsize  = ifu_arsize;
                out_arburst = ifu_arburst;
                ifu_arready = out_arready;
                ifu_rvalid  = out_rvalid;
                out_rready  = ifu_rready;
                if (out_rvalid && ifu_rready && out_rlast) state_d = IDLE;
            end
            LSU_RD: begin
                out_arvalid = lsu_arvalid;
                out_araddr  = lsu_araddr;
                out_arid    = lsu_arid;
                out_arlen   = lsu_arlen;
                out_arsize  = lsu_arsize;
                out_arburst = lsu_arburst;
                lsu_arready = out_arready;
                lsu_rvalid  = out_rvalid;
                out_rready  = lsu_rready;
                if (out_rvalid && lsu_rready && out_rlast) state_d = IDLE;
            end
            LSU_WR: begin
                out_awvalid = lsu_awvalid;
                out_awaddr  = lsu_awaddr;
                out_awid    = lsu_awid;
                out_awlen   = lsu_awlen;
                out_awsize  = lsu_awsize;
                out_awburst = lsu_awburst;
                lsu_awready = out_awready;
                out_wvalid  = lsu_wvalid;
                out_wdata   = lsu_wdata;
                out_wstrb   = lsu_wstrb;
                out_wlast   = lsu_wlast;
                lsu_wready  = out_wready;
                lsu_bvalid  = out_bvalid;
                out_bready  = lsu_bready;
                if (out_bvalid && lsu_bready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060236_arbiter.sv
// ============================================================================
// tb_ysyx_23060236_arbiter - scoreboard bench with a simple downstream AXI slave. Rev 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_23060236_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rlast, ifu_rready;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic [3:0]  ifu_arid, ifu_rid;
    logic [7:0]  ifu_arlen;
    logic [2:0]  ifu_arsize;
    logic [1:0]  ifu_arburst, ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rlast, lsu_rready;
    logic [31:0] lsu_araddr, lsu_rdata;
    logic [3:0]  lsu_arid, lsu_rid;
    logic [7:0]  lsu_arlen;
    logic [2:0]  lsu_arsize;
    logic [1:0]  lsu_arburst, lsu_rresp;
    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wlast, lsu_wready;
    logic        lsu_bvalid, lsu_bready;
    logic [31:0] lsu_awaddr, lsu_wdata;
    logic [3:0]  lsu_awid, lsu_wstrb, lsu_bid;
    logic [7:0]  lsu_awlen;
    logic [2:0]  lsu_awsize;
    logic [1:0]  lsu_awburst, lsu_bresp;
    logic        out_awvalid, out_awready, out_wvalid, out_wready, out_wlast;
    logic        out_bvalid, out_bready, out_arvalid, out_arready, out_rvalid, out_rready, out_rlast;
    logic [31:0] out_awaddr, out_wdata, out_araddr, out_rdata;
    logic [3:0]  out_awid, out_wstrb, out_bid, out_arid, out_rid;
    logic [7:0]  out_awlen, out_arlen;
    logic [2:0]  out_awsize, out_arsize;
    logic [1:0]  out_awburst, out_bresp, out_arburst, out_rresp;

    ysyx_23060236_arbiter dut (
        .clock(clock), .reset(reset),
        .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arid(ifu_arid),
        .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst),
        .ifu_arready(ifu_arready), .ifu_rvalid(ifu_rvalid), .ifu_rresp(ifu_rresp),
        .ifu_rdata(ifu_rdata), .ifu_rlast(ifu_rlast), .ifu_rid(ifu_rid), .ifu_rready(ifu_rready),
        .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arid(lsu_arid),
        .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst),
        .lsu_arready(lsu_arready), .lsu_rvalid(lsu_rvalid), .lsu_rresp(lsu_rresp),
        .lsu_rdata(lsu_rdata), .lsu_rlast(lsu_rlast), .lsu_rid(lsu_rid), .lsu_rready(lsu_rready),
        .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awid(lsu_awid),
        .lsu_awlen(lsu_awlen), .lsu_awsize(lsu_awsize), .lsu_awburst(lsu_awburst),
        .lsu_awready(lsu_awready), .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast), .lsu_wready(lsu_wready),
        .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bid(lsu_bid), .lsu_bready(lsu_bready),
        .out_awvalid(out_awvalid), .out_awready(out_awready), .out_awaddr(out_awaddr),
        .out_awid(out_awid), .out_awlen(out_awlen), .out_awsize(out_awsize), .out_awburst(out_awburst),
        .out_wvalid(out_wvalid), .out_wready(out_wready), .out_wdata(out_wdata),
        .out_wstrb(out_wstrb), .out_wlast(out_wlast),
        .out_bvalid(out_bvalid), .out_bready(out_bready), .out_bresp(out_bresp), .out_bid(out_bid),
        .out_arvalid(out_arvalid), .out_arready(out_arready), .out_araddr(out_araddr),
        .out_arid(out_arid), .out_arlen(out_arlen), .out_arsize(out_arsize), .out_arburst(out_arburst),
        .out_rvalid(out_rvalid), .out_rready(out_rready), .out_rresp(out_rresp),
        .out_rdata(out_rdata), .out_rlast(out_rlast), .out_rid(out_rid)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;

    // Expected-response queues: ar={ifu_ack,lsu_ack,addr,id,len}, r={data,last},
    // aw={lsu_ack,addr,id,len}, w={lsu_ack,data,strb,last}, b={id,resp}.
    logic [45:0] q_ar[$];
    logic [32:0] q_ifu_r[$];
    logic [32:0] q_lsu_r[$];
    logic [44:0] q_aw[$];
    logic [37:0] q_w[$];
    logic [5:0]  q_b[$];
    logic [31:0] slv_data[$];
    logic        toggle_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_checks++;
        n_err++;
        $display("FAIL %s: got handshake %h required none (t=%0t)", name, act, $time);
    endtask

    // Monitor: pops the scoreboard whenever a handshake is visible
    initial begin
        logic [63:0] a;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (out_arvalid && out_arready) begin
                    a = 64'({ifu_arready, lsu_arready, out_araddr, out_arid, out_arlen});
                    if (q_ar.size() == 0) unexpected("ar_unexpected", a);
                    else begin
                        chk("ar", a, 64'(q_ar.pop_front()));
                        chk("ar_size", 64'(out_arsize), 64'(3'b010));
                    end
                end
                if (ifu_rvalid && ifu_rready) begin
                    a = 64'({ifu_rdata, ifu_rlast});
                    if (q_ifu_r.size() == 0) unexpected("ifu_r_unexpected", a);
                    else chk("ifu_r", a, 64'(q_ifu_r.pop_front()));
                    chk("ifu_r_lsu_masked", 64'(lsu_rvalid), 64'(0));
                end
                if (lsu_rvalid && lsu_rready) begin
                    a = 64'({lsu_rdata, lsu_rlast});
                    if (q_lsu_r.size() == 0) unexpected("lsu_r_unexpected", a);
                    else chk("lsu_r", a, 64'(q_lsu_r.pop_front()));
                    chk("lsu_r_ifu_masked", 64'(ifu_rvalid), 64'(0));
                end
                if (out_awvalid && out_awready) begin
                    a = 64'({lsu_awready, out_awaddr, out_awid, out_awlen});
                    if (q_aw.size() == 0) unexpected("aw_unexpected", a);
                    else chk("aw", a, 64'(q_aw.pop_front()));
                end
                if (out_wvalid && out_wready) begin
                    a = 64'({lsu_wready, out_wdata, out_wstrb, out_wlast});
                    if (q_w.size() == 0) unexpected("w_unexpected", a);
                    else chk("w", a, 64'(q_w.pop_front()));
                end
                if (lsu_bvalid && lsu_bready) begin
                    a = 64'({lsu_bid, lsu_bresp});
                    if (q_b.size() == 0) unexpected("b_unexpected", a);
                    else chk("b", a, 64'(q_b.pop_front()));
                end
            end
        end
    end

    // Downstream slave: always ready for addresses and data, streams R beats
    // from slv_data, answers a write one cycle after its last W beat.
    initial begin
        logic ar_hs, r_hs, aw_hs, wl_hs, b_hs;
        logic [7:0] arlen_s;
        logic [3:0] arid_s, awid_s, bid_s;
        int beats;
        out_arready = 1'b1; out_awready = 1'b1; out_wready = 1'b1;
        out_rvalid = 1'b0; out_rdata = 32'd0; out_rlast = 1'b0; out_rid = 4'd0; out_rresp = 2'd0;
        out_bvalid = 1'b0; out_bid = 4'd0; out_bresp = 2'd0;
        bid_s = 4'd0; beats = 0;
        forever begin
            @(negedge clock);
            ar_hs = out_arvalid & out_arready; arlen_s = out_arlen; arid_s = out_arid;
            r_hs  = out_rvalid & out_rready;
            aw_hs = out_awvalid & out_awready; awid_s = out_awid;
            wl_hs = out_wvalid & out_wready & out_wlast;
            b_hs  = out_bvalid & out_bready;
            @(posedge clock); #1;
            if (reset) begin
                out_rvalid = 1'b0; out_bvalid = 1'b0; beats = 0;
            end else begin
                if (r_hs) begin
                    if (beats <= 1) begin
                        out_rvalid = 1'b0; out_rlast = 1'b0; beats = 0;
                    end else begin
                        beats--;
                        out_rdata = (slv_data.size() > 0) ? slv_data.pop_front() : 32'hBAD0BAD0;
                        out_rlast = (beats == 1);
                    end
                end
                if (ar_hs) begin
                    beats      = int'(arlen_s) + 1;
                    out_rvalid = 1'b1;
                    out_rid    = arid_s;
                    out_rdata  = (slv_data.size() > 0) ? slv_data.pop_front() : 32'hBAD0BAD0;
                    out_rlast  = (arlen_s == 8'd0);
                end
                if (aw_hs) bid_s = awid_s;
                if (b_hs) out_bvalid = 1'b0;
                if (wl_hs) begin out_bvalid = 1'b1; out_bid = bid_s; end
            end
        end
    end

    initial begin
        ifu_rready = 1'b1;
        forever begin
            @(posedge clock); #1;
            ifu_rready = toggle_en ? ~ifu_rready : 1'b1;
        end
    end

    // All master tasks are entered and left 1 time unit after a rising edge.
    task automatic ifu_read(input logic [31:0] addr, input logic [7:0] len);
        int t; logic done;
        ifu_arvalid = 1'b1; ifu_araddr = addr; ifu_arid = 4'h1; ifu_arlen = len;
        ifu_arsize = 3'b010; ifu_arburst = 2'b01;
        t = 0; done = 1'b0;
        while (!done && t < 200) begin @(negedge clock); t++; done = ifu_arready; end
        chk("ifu_ar_handshake_seen", 64'(done), 64'(1));
        @(posedge clock); #1; ifu_arvalid = 1'b0;
        t = 0; done = 1'b0;
        while (!done && t < 400) begin
            @(negedge clock); t++; done = ifu_rvalid & ifu_rready & ifu_rlast;
        end
        chk("ifu_rlast_seen", 64'(done), 64'(1));
        @(posedge clock); #1;
    endtask

    task automatic lsu_read(input logic [31:0] addr, input logic [7:0] len);
        int t; logic done;
        lsu_arvalid = 1'b1; lsu_araddr = addr; lsu_arid = 4'h2; lsu_arlen = len;
        lsu_arsize = 3'b010; lsu_arburst = 2'b01;
        t = 0; done = 1'b0;
        while (!done && t < 200) begin @(negedge clock); t++; done = lsu_arready; end
        chk("lsu_ar_handshake_seen", 64'(done), 64'(1));
        @(posedge clock); #1; lsu_arvalid = 1'b0;
        t = 0; done = 1'b0;
        while (!done && t < 400) begin
            @(negedge clock); t++; done = lsu_rvalid & lsu_rready & lsu_rlast;
        end
        chk("lsu_rlast_seen", 64'(done), 64'(1));
        @(posedge clock); #1;
    endtask

    task automatic lsu_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int t; logic a, w, done;
        lsu_awvalid = 1'b1; lsu_awaddr = addr; lsu_awid = 4'h3; lsu_awlen = 8'd0;
        lsu_awsize = 3'b010; lsu_awburst = 2'b01;
        lsu_wvalid = 1'b1; lsu_wdata = data; lsu_wstrb = strb; lsu_wlast = 1'b1;
        t = 0;
        while ((lsu_awvalid || lsu_wvalid) && t < 200) begin
            @(negedge clock); t++; a = lsu_awready & lsu_awvalid; w = lsu_wready & lsu_wvalid;
            @(posedge clock); #1;
            if (a) lsu_awvalid = 1'b0;
            if (w) lsu_wvalid = 1'b0;
        end
        chk("lsu_aw_w_accepted", 64'({lsu_awvalid, lsu_wvalid}), 64'(0));
        t = 0; done = 1'b0;
        while (!done && t < 200) begin @(negedge clock); t++; done = lsu_bvalid & lsu_bready; end
        chk("lsu_b_seen", 64'(done), 64'(1));
        @(posedge clock); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion required completion");
        $fatal(1);
    end

    initial begin
        int t, cnt;
        logic seen_arready, seen_arvalid, done;
        reset = 1'b1;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000; ifu_arid = 4'h1; ifu_arlen = 8'd0;
        ifu_arsize = 3'b010; ifu_arburst = 2'b01;
        lsu_arvalid = 1'b0; lsu_araddr = 32'd0; lsu_arid = 4'd0; lsu_arlen = 8'd0;
        lsu_arsize = 3'b010; lsu_arburst = 2'b01; lsu_rready = 1'b1;
        lsu_awvalid = 1'b1; lsu_awaddr = 32'd0; lsu_awid = 4'd0; lsu_awlen = 8'd0;
        lsu_awsize = 3'b010; lsu_awburst = 2'b01;
        lsu_wvalid = 1'b0; lsu_wdata = 32'd0; lsu_wstrb = 4'd0; lsu_wlast = 1'b0; lsu_bready = 1'b1;

        // Reset holds everything idle even with requests pending
        repeat (2) @(negedge clock);
        chk("rst_valids_readies", 64'({out_arvalid, out_awvalid, out_wvalid, out_bready, out_rready,
            ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid}), 64'(0));
        chk("rst_masked_sizes", 64'({out_arsize, out_awsize}), 64'(6'b010_010));
        chk("rst_masked_addr", 64'({out_araddr, out_awaddr}), 64'(0));
        ifu_arvalid = 1'b0; lsu_awvalid = 1'b0;
        @(negedge clock); #2 reset = 1'b0;
        @(posedge clock); #1;

        // IFU single read: one-cycle arbitration latency, IDLE after rlast
        q_ar.push_back({1'b1, 1'b0, 32'h8000_0000, 4'h1, 8'd0});
        q_ifu_r.push_back({32'h1234_5678, 1'b1});
        slv_data.push_back(32'h1234_5678);
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000; ifu_arlen = 8'd0;
        @(negedge clock);
        chk("lat_idle_arvalid", 64'(out_arvalid), 64'(0));
        @(negedge clock);
        chk("lat_granted_arvalid", 64'(out_arvalid), 64'(1));
        @(posedge clock); #1; ifu_arvalid = 1'b0;
        @(negedge clock);
        chk("single_rvalid_routing", 64'({ifu_rvalid, lsu_rvalid}), 64'(2'b10));
        @(posedge clock); #1;
        @(negedge clock);
        chk("idle_after_rlast", 64'({out_rready, ifu_arready, ifu_rvalid}), 64'(0));
        @(posedge clock); #1;

        // Contention with last grant = IFU: LSU first, then IFU
        q_ar.push_back({1'b0, 1'b1, 32'h8000_2000, 4'h2, 8'd0});
        q_ar.push_back({1'b1, 1'b0, 32'h8000_1000, 4'h1, 8'd0});
        slv_data.push_back(32'hAAAA_0001); slv_data.push_back(32'hBBBB_0002);
        q_lsu_r.push_back({32'hAAAA_0001, 1'b1});
        q_ifu_r.push_back({32'hBBBB_0002, 1'b1});
        fork
            ifu_read(32'h8000_1000, 8'd0);
            lsu_read(32'h8000_2000, 8'd0);
        join

        // LSU alone leaves last grant = LSU, so the next contention goes to IFU
        q_ar.push_back({1'b0, 1'b1, 32'h8000_3000, 4'h2, 8'd0});
        slv_data.push_back(32'hCCCC_0003);
        q_lsu_r.push_back({32'hCCCC_0003, 1'b1});
        lsu_read(32'h8000_3000, 8'd0);
        q_ar.push_back({1'b1, 1'b0, 32'h8000_1004, 4'h1, 8'd0});
        q_ar.push_back({1'b0, 1'b1, 32'h8000_2004, 4'h2, 8'd0});
        slv_data.push_back(32'hDDDD_0004); slv_data.push_back(32'hEEEE_0005);
        q_ifu_r.push_back({32'hDDDD_0004, 1'b1});
        q_lsu_r.push_back({32'hEEEE_0005, 1'b1});
        fork
            ifu_read(32'h8000_1004, 8'd0);
            lsu_read(32'h8000_2004, 8'd0);
        join

        // Put last grant back on IFU, then LSU write against a pending IFU read
        q_ar.push_back({1'b1, 1'b0, 32'h8000_1008, 4'h1, 8'd0});
        slv_data.push_back(32'h1111_0006);
        q_ifu_r.push_back({32'h1111_0006, 1'b1});
        ifu_read(32'h8000_1008, 8'd0);
        q_aw.push_back({1'b1, 32'h8000_0100, 4'h3, 8'd0});
        q_w.push_back({1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1});
        q_b.push_back({4'h3, 2'b00});
        q_ar.push_back({1'b1, 1'b0, 32'h8000_100C, 4'h1, 8'd0});
        slv_data.push_back(32'h2222_0007);
        q_ifu_r.push_back({32'h2222_0007, 1'b1});
        fork
            lsu_write(32'h8000_0100, 32'hDEAD_BEEF, 4'hF);
            ifu_read(32'h8000_100C, 8'd0);
            begin
                seen_arready = 1'b0; seen_arvalid = 1'b0; done = 1'b0; t = 0;
                while (!done && t < 200) begin
                    @(negedge clock); t++;
                    seen_arready |= ifu_arready;
                    seen_arvalid |= out_arvalid;
                    done = lsu_bvalid & lsu_bready;
                end
                chk("ifu_arready_during_write", 64'(seen_arready), 64'(0));
                chk("out_arvalid_during_write", 64'(seen_arvalid), 64'(0));
            end
        join

        // IFU 4-beat burst with throttled rready; LSU read waits for rlast
        q_ar.push_back({1'b1, 1'b0, 32'h8000_0200, 4'h1, 8'd3});
        q_ar.push_back({1'b0, 1'b1, 32'h8000_0300, 4'h2, 8'd0});
        for (int i = 0; i < 4; i++) begin
            slv_data.push_back(32'h5000_0000 + 32'(i));
            q_ifu_r.push_back({32'h5000_0000 + 32'(i), i == 3});
        end
        slv_data.push_back(32'h6666_0008);
        q_lsu_r.push_back({32'h6666_0008, 1'b1});
        toggle_en = 1'b1;
        fork
            ifu_read(32'h8000_0200, 8'd3);
            begin
                @(posedge clock); #1;
                lsu_read(32'h8000_0300, 8'd0);
            end
            begin
                cnt = 0; done = 1'b0; t = 0;
                while (!done && t < 200) begin
                    @(negedge clock); t++;
                    if (ifu_rvalid && ifu_rready) cnt++;
                    done = out_arvalid & out_arready & (out_arid == 4'h2);
                end
                chk("lsu_ar_after_ifu_beats", 64'(cnt), 64'(4));
            end
        join
        toggle_en = 1'b0;
        @(posedge clock); #1;

        // Asynchronous reset after beat 2 of a 4-beat IFU burst
        q_ar.push_back({1'b1, 1'b0, 32'h8000_0400, 4'h1, 8'd3});
        for (int i = 0; i < 4; i++) begin
            slv_data.push_back(32'h7000_0000 + 32'(i));
            q_ifu_r.push_back({32'h7000_0000 + 32'(i), i == 3});
        end
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0400; ifu_arlen = 8'd3;
        done = 1'b0; t = 0;
        while (!done && t < 50) begin @(negedge clock); t++; done = ifu_arready; end
        @(posedge clock); #1; ifu_arvalid = 1'b0;
        cnt = 0; t = 0;
        while (cnt < 2 && t < 50) begin
            @(negedge clock); t++;
            if (ifu_rvalid && ifu_rready) cnt++;
        end
        chk("beats_before_reset", 64'(cnt), 64'(2));
        @(posedge clock); #3 reset = 1'b1;
        #1;
        chk("async_reset_outputs", 64'({out_rready, ifu_rvalid, lsu_rvalid, out_arvalid,
            ifu_arready, out_awvalid}), 64'(0));
        chk("abandoned_beats", 64'(q_ifu_r.size()), 64'(2));
        q_ifu_r.delete();
        slv_data.delete();
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        @(posedge clock); #1;

        // Fresh LSU read after reset, then IFU wins the following contention
        q_ar.push_back({1'b0, 1'b1, 32'h8000_0500, 4'h2, 8'd0});
        slv_data.push_back(32'h8888_0009);
        q_lsu_r.push_back({32'h8888_0009, 1'b1});
        lsu_read(32'h8000_0500, 8'd0);
        q_ar.push_back({1'b1, 1'b0, 32'h8000_0600, 4'h1, 8'd0});
        q_ar.push_back({1'b0, 1'b1, 32'h8000_0700, 4'h2, 8'd0});
        slv_data.push_back(32'h9999_000A); slv_data.push_back(32'hAAAA_000B);
        q_ifu_r.push_back({32'h9999_000A, 1'b1});
        q_lsu_r.push_back({32'hAAAA_000B, 1'b1});
        fork
            ifu_read(32'h8000_0600, 8'd0);
            lsu_read(32'h8000_0700, 8'd0);
        join

        repeat (3) @(negedge clock);
        chk("scoreboard_drained", 64'(q_ar.size() + q_ifu_r.size() + q_lsu_r.size()
            + q_aw.size() + q_w.size() + q_b.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
